nword_dataunit: RTL and testbench
=================================

# nword_dataunit

Parametrised cache-line data store for the L1 data/instruction caches: `INDEXWIDTH`-deep sets of `WORDS`-word lines with byte-masked CPU writes and registered reads. It also contains a line-fill sequencer that writes a burst from the memory side into one line. The burst starts at the critical word and wraps around the line, and the critical word is forwarded on the read port. It sits between the cache controller (CPU-side request and fill commands) and the bus/memory return path.

## Interface
- `DATAWIDTH`, 32: word width in bits; must be a multiple of 8.
- `INDEXWIDTH`, 6: line index width; depth = 2**INDEXWIDTH lines.
- `WORDS`, 4: words per line; a power of 2, ≥2.
- `OFFW`, $clog2(WORDS): word-offset width (derived, not overridden).
- `BYTES`, DATAWIDTH/8: byte lanes per word (derived).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  CPU-side access request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_index`  in  INDEXWIDTH  line index.
- `req_offset`  in  OFFW  word within the line.
- `req_web`  in  BYTES  active-low byte-write enables; bit i covers bits [8i+7:8i].
- `req_wdata`  in  DATAWIDTH  write data.
- `req_ready`  out  1  request accepted this cycle when req_valid is also high.
- `rdata`  out  DATAWIDTH  read / forwarded data.
- `rdata_valid`  out  1  one-cycle pulse qualifying `rdata`.
- `fill_start`  in  1  begin a line fill.
- `fill_index`  in  INDEXWIDTH  line being filled; sampled with `fill_start`.
- `fill_offset`  in  OFFW  critical-word offset; sampled with `fill_start`.
- `fill_valid`  in  1  fill beat present.
- `fill_data`  in  DATAWIDTH  fill beat data; full-word write.
- `busy`  out  1  fill in progress.
- `fill_done`  out  1  one-cycle pulse after the last beat is written.

## Operation
- FSM states are IDLE and FILL. Reset state is IDLE.
- Reset values: `rdata`=0, `rdata_valid`=0, `fill_done`=0, `busy`=0, beat counter=0. Array contents are not reset.
- `req_ready` = (state==IDLE) && !fill_start. A request is accepted when req_valid && req_ready.
- Accepted read:
  - `rdata` ← word[req_index][req_offset] on the next edge.
  - `rdata_valid` pulses for one cycle.
- Accepted write:
  - On the next edge, write only the byte lanes whose `req_web` bit is 0.
  - If `req_web` is all 1s, no bytes change.
  - No `rdata_valid` pulse.
- IDLE with `fill_start`=1:
  - Latch `fill_index` and `fill_offset`, clear the counter, go to FILL.
  - `fill_start` has priority over `req_valid` in the same cycle.
- FILL, each cycle with `fill_valid`=1:
  - Write `fill_data` to word (fill_offset + cnt) mod WORDS of the latched line, then increment `cnt`.
  - The wrap-around is natural OFFW-bit overflow.
  - Cycles with `fill_valid`=0 are stalls: nothing changes.
- First beat (cnt==0): `rdata` ← `fill_data` and `rdata_valid` pulses on the next cycle (critical-word forward). Later beats do not touch `rdata`.
- Beat with cnt==WORDS-1:
  - Go to IDLE and pulse `fill_done` on the next cycle.
  - `busy` drops in the same edge.
- `fill_start` during FILL is ignored. `req_valid` during FILL is not accepted (`req_ready`=0).
- `rdata` holds its last value when `rdata_valid`=0.
- `rst` asserted mid-fill:
  - Return to IDLE immediately and clear the counter.
  - Words already written stay written.
  - No `fill_done` pulse.

## Timing
- Read latency is 1 cycle: request accepted at edge N, data valid in cycle N+1.
- Write-then-read to the same word on consecutive cycles returns the new data.
- A fill with back-to-back `fill_valid` takes exactly WORDS cycles in FILL.
  - Critical-word `rdata_valid` is 1 cycle after the first beat.
  - `fill_done` is 1 cycle after the last beat.
  - `req_ready` is high again in the same cycle as `fill_done`.
- Minimum spacing between fills is 1 IDLE cycle: `fill_start` may be asserted in the cycle `fill_done` is high.
- `busy` is registered and equals (state==FILL).

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` asynchronously between edges.
  - Required: all outputs go to 0 and `req_ready`=1 without waiting for a clock edge.
- Byte-masked write then read, DATAWIDTH=32:
  - Stimulus: write 0xAABBCCDD with web=0000 to index 5, offset 2; then write 0x11223344 with web=1010; then read.
  - Required: 0xAA22CC44 with `rdata_valid` high 1 cycle after the read.
- Wrapped fill with forwarding, WORDS=4:
  - Stimulus: fill index 9, offset 3, beats D0..D3 back-to-back.
  - Required: `rdata`=D0 with a pulse 1 cycle later; `fill_done` after beat 4; reads of offsets 3,0,1,2 return D0,D1,D2,D3.
- Stalled fill:
  - Stimulus: gap of 3 idle cycles between beats 1 and 2.
  - Required: `busy` stays high; the word order is identical to the back-to-back case.
- Priority and blocking:
  - Stimulus: `fill_start` and a read in the same cycle; then reads during FILL.
  - Required: `req_ready`=0 throughout; no read is performed; `fill_start` issued during FILL has no effect.
- Reset mid-fill:
  - Stimulus: `rst` after 2 of 4 beats.
  - Required: IDLE, no `fill_done`; the 2 written words read back; the other words are unchanged.

Source files
------------

// File: rtl/nword_dataunit.sv
// rtl/nword_dataunit.sv - cache-line data store with byte-masked writes and wrapped line fill
//
// Purpose: 2**INDEXWIDTH lines of WORDS words each. The CPU side performs
// registered reads and byte-masked writes; the fill side writes a burst
// into one line starting at the critical word, wrapping around the line,
// and forwards the critical word on the read port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_write request strobe and direction (1 = write)
//   req_index/offset    target line and word
//   req_web             active-low byte-write enables
//   req_wdata           write data
//   req_ready           request accepted when high together with req_valid
//   rdata/rdata_valid   read or forwarded data with one-cycle qualifier
//   fill_start          begin a fill; fill_index/fill_offset sampled with it
//   fill_valid/data     fill beat strobe and data
//   busy                fill in progress
//   fill_done           one-cycle pulse after the last beat is written
module nword_dataunit #(
  parameter int DATAWIDTH  = 32,
  parameter int INDEXWIDTH = 6,
  parameter int WORDS      = 4,
  localparam int OFFW      = $clog2(WORDS),
  localparam int BYTES     = DATAWIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [INDEXWIDTH-1:0] req_index,
  input  logic [OFFW-1:0]       req_offset,
  input  logic [BYTES-1:0]      req_web,
  input  logic [DATAWIDTH-1:0]  req_wdata,
  output logic                  req_ready,
  output logic [DATAWIDTH-1:0]  rdata,
  output logic                  rdata_valid,
  input  logic                  fill_start,
  input  logic [INDEXWIDTH-1:0] fill_index,
  input  logic [OFFW-1:0]       fill_offset,
  input  logic                  fill_valid,
  input  logic [DATAWIDTH-1:0]  fill_data,
  output logic                  busy,
  output logic                  fill_done
);

  localparam int AW    = INDEXWIDTH + OFFW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  logic [DATAWIDTH-1:0]  r_mem [DEPTH];
  state_t                r_state;
  logic [OFFW-1:0]       r_cnt;
  logic [OFFW-1:0]       r_foff;
  logic [INDEXWIDTH-1:0] r_fidx;
  logic [DATAWIDTH-1:0]  r_rdata;
  logic                  r_rvalid;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_req_acc;
  logic                  w_cpu_rd;
  logic                  w_cpu_wr;
  logic                  w_beat;
  logic                  w_last;
  logic [OFFW-1:0]       w_fill_off;
  logic [AW-1:0]         w_req_addr;
  logic                  w_wr_en;
  logic [AW-1:0]         w_wr_addr;
  logic [DATAWIDTH-1:0]  w_wr_data;
  logic [BYTES-1:0]      w_wr_mask;

  assign req_ready   = (r_state == S_IDLE) && !fill_start;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rvalid;
  assign busy        = r_busy;
  assign fill_done   = r_done;

  assign w_req_acc  = req_valid && req_ready;
  assign w_cpu_rd   = w_req_acc && !req_write;
  assign w_cpu_wr   = w_req_acc && req_write;
  assign w_beat     = (r_state == S_FILL) && fill_valid;
  assign w_last     = w_beat && (r_cnt == OFFW'(WORDS - 1));
  // OFFW-bit sum: overflow is exactly the wrap-around within the line.
  assign w_fill_off = r_foff + r_cnt;
  assign w_req_addr = {req_index, req_offset};

  // CPU writes only happen in IDLE and fill beats only in FILL, so the two
  // write sources never collide on the single array port.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = w_req_addr;
    w_wr_data = req_wdata;
    w_wr_mask = '0;
    if (w_beat) begin
      w_wr_en   = 1'b1;
      w_wr_addr = {r_fidx, w_fill_off};
      w_wr_data = fill_data;
      w_wr_mask = '1;
    end else if (w_cpu_wr) begin
      w_wr_en   = 1'b1;
      w_wr_mask = ~req_web;
    end
  end

  // Array is not reset; writes are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_wr_mask[b]) begin
          r_mem[w_wr_addr][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_foff   <= '0;
      r_fidx   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fill_start) begin
            r_fidx  <= fill_index;
            r_foff  <= fill_offset;
            r_cnt   <= '0;
            r_state <= S_FILL;
            r_busy  <= 1'b1;
          end else if (w_cpu_rd) begin
            r_rdata  <= r_mem[w_req_addr];
            r_rvalid <= 1'b1;
          end
        end
        S_FILL: begin
          if (fill_valid) begin
            // Critical word is forwarded as soon as it arrives.
            if (r_cnt == '0) begin
              r_rdata  <= fill_data;
              r_rvalid <= 1'b1;
            end
            r_cnt <= r_cnt + OFFW'(1);
            if (w_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nword_dataunit.sv
// tb/tb_nword_dataunit.sv - randomized self-checking bench for nword_dataunit
module tb_nword_dataunit;

  localparam int DW    = 32;
  localparam int IW    = 6;
  localparam int WORDS = 4;
  localparam int OFFW  = 2;
  localparam int NBYTE = 4;
  localparam int LINES = 1 << IW;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_write;
  logic [IW-1:0]    req_index;
  logic [OFFW-1:0]  req_offset;
  logic [NBYTE-1:0] req_web;
  logic [DW-1:0]    req_wdata;
  logic             req_ready;
  logic [DW-1:0]    rdata;
  logic             rdata_valid;
  logic             fill_start;
  logic [IW-1:0]    fill_index;
  logic [OFFW-1:0]  fill_offset;
  logic             fill_valid;
  logic [DW-1:0]    fill_data;
  logic             busy;
  logic             fill_done;

  logic [DW-1:0] m_mem [LINES][WORDS];
  int n_checks;
  int n_fail;

  nword_dataunit #(.DATAWIDTH(DW), .INDEXWIDTH(IW), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_index(req_index),
    .req_offset(req_offset), .req_web(req_web), .req_wdata(req_wdata),
    .req_ready(req_ready), .rdata(rdata), .rdata_valid(rdata_valid),
    .fill_start(fill_start), .fill_index(fill_index), .fill_offset(fill_offset),
    .fill_valid(fill_valid), .fill_data(fill_data),
    .busy(busy), .fill_done(fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_index   = '0;
    req_offset  = '0;
    req_web     = '1;
    req_wdata   = '0;
    fill_start  = 1'b0;
    fill_index  = '0;
    fill_offset = '0;
    fill_valid  = 1'b0;
    fill_data   = '0;
  endtask

  // Junk CPU requests and fill_start pulses that must all be ignored during FILL.
  task automatic junk_inputs();
    req_valid   = 1'($urandom);
    req_write   = 1'($urandom);
    req_index   = IW'($urandom);
    req_offset  = OFFW'($urandom);
    req_web     = NBYTE'($urandom);
    req_wdata   = $urandom;
    fill_start  = 1'($urandom);
    fill_index  = IW'($urandom);
    fill_offset = OFFW'($urandom);
  endtask

  task automatic cpu_write(input int idx, input int off, input logic [NBYTE-1:0] web,
                           input logic [DW-1:0] data);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_index  = IW'(idx);
    req_offset = OFFW'(off);
    req_web    = web;
    req_wdata  = data;
    #1;
    check("wr_ready", 32'(req_ready), 32'd1);
    step();
    idle_inputs();
    for (int b = 0; b < NBYTE; b++)
      if (!web[b]) m_mem[idx][off][8*b +: 8] = data[8*b +: 8];
    check("wr_no_rvalid", 32'(rdata_valid), 32'd0);
  endtask

  task automatic read_expect(input string tag, input int idx, input int off,
                             input logic [DW-1:0] exp);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_index  = IW'(idx);
    req_offset = OFFW'(off);
    #1;
    check("rd_ready", 32'(req_ready), 32'd1);
    step();
    idle_inputs();
    check("rd_valid", 32'(rdata_valid), 32'd1);
    check(tag, rdata, exp);
  endtask

  task automatic cpu_read(input int idx, input int off);
    read_expect("rd_data", idx, off, m_mem[idx][off]);
  endtask

  // abort_after < WORDS asserts rst asynchronously once that many beats are written.
  task automatic do_fill(input int idx, input int off, input logic [DW-1:0] d [WORDS],
                         input int stall_before, input int stall_len, input bit junk,
                         input int abort_after);
    fill_start  = 1'b1;
    fill_index  = IW'(idx);
    fill_offset = OFFW'(off);
    if (junk) begin
      req_valid  = 1'b1;
      req_write  = 1'($urandom);
      req_index  = IW'($urandom);
      req_offset = OFFW'($urandom);
      req_web    = NBYTE'($urandom);
      req_wdata  = $urandom;
    end
    #1;
    check("fs_ready", 32'(req_ready), 32'd0);
    step();
    idle_inputs();
    check("fs_busy", 32'(busy), 32'd1);
    check("fs_no_rvalid", 32'(rdata_valid), 32'd0);
    for (int b = 0; b < WORDS; b++) begin
      if (b == abort_after) begin
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(fill_done), 32'd0);
        check("abort_rvalid", 32'(rdata_valid), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        step();
        check("abort_no_done", 32'(fill_done), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        return;
      end
      if (b == stall_before) begin
        for (int s = 0; s < stall_len; s++) begin
          fill_valid = 1'b0;
          if (junk) junk_inputs();
          #1;
          check("stall_ready", 32'(req_ready), 32'd0);
          step();
          idle_inputs();
          check("stall_busy", 32'(busy), 32'd1);
          check("stall_rvalid", 32'(rdata_valid), 32'd0);
          check("stall_done", 32'(fill_done), 32'd0);
        end
      end
      if (junk) junk_inputs();
      fill_valid = 1'b1;
      fill_data  = d[b];
      step();
      idle_inputs();
      #1;
      m_mem[idx][(off + b) % WORDS] = d[b];
      if (b == 0) begin
        check("crit_rvalid", 32'(rdata_valid), 32'd1);
        check("crit_rdata", rdata, d[0]);
      end else begin
        check("beat_rvalid", 32'(rdata_valid), 32'd0);
      end
      if (b == WORDS - 1) begin
        check("done_pulse", 32'(fill_done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_ready", 32'(req_ready), 32'd1);
      end else begin
        check("beat_done", 32'(fill_done), 32'd0);
        check("beat_busy", 32'(busy), 32'd1);
      end
    end
  endtask

  logic [DW-1:0] dd [WORDS];

  task automatic rand_line();
    for (int k = 0; k < WORDS; k++) dd[k] = $urandom;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_rvalid", 32'(rdata_valid), 32'd0);
    check("rst_done", 32'(fill_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < LINES; i++)
      for (int w = 0; w < WORDS; w++)
        cpu_write(i, w, 4'b0000, $urandom);

    cpu_write(5, 2, 4'b0000, 32'hAABBCCDD);
    cpu_write(5, 2, 4'b1010, 32'h11223344);
    read_expect("bytemask", 5, 2, 32'hAA22CC44);
    cpu_write(5, 2, 4'b1111, 32'h55667788);
    read_expect("web_all_ones", 5, 2, 32'hAA22CC44);

    rand_line();
    do_fill(9, 3, dd, -1, 0, 1'b0, WORDS);
    read_expect("wrap_o3", 9, 3, dd[0]);
    read_expect("wrap_o0", 9, 0, dd[1]);
    read_expect("wrap_o1", 9, 1, dd[2]);
    read_expect("wrap_o2", 9, 2, dd[3]);

    rand_line();
    do_fill(9, 3, dd, 1, 3, 1'b0, WORDS);
    read_expect("stall_o3", 9, 3, dd[0]);
    read_expect("stall_o0", 9, 0, dd[1]);
    read_expect("stall_o1", 9, 1, dd[2]);
    read_expect("stall_o2", 9, 2, dd[3]);

    rand_line();
    do_fill(20, 1, dd, 2, 2, 1'b1, WORDS);
    for (int w = 0; w < WORDS; w++) cpu_read(20, w);

    rand_line();
    do_fill(21, 0, dd, -1, 0, 1'b0, WORDS);
    rand_line();
    do_fill(22, 2, dd, -1, 0, 1'b0, WORDS);
    for (int w = 0; w < WORDS; w++) cpu_read(21, w);
    for (int w = 0; w < WORDS; w++) cpu_read(22, w);

    rand_line();
    do_fill(30, 2, dd, -1, 0, 1'b0, 2);
    for (int w = 0; w < WORDS; w++) cpu_read(30, w);

    for (int n = 0; n < 300; n++) begin
      int op;
      int idx;
      idx = int'($urandom_range(0, 7));
      op  = int'($urandom_range(0, 9));
      if (op < 4) begin
        cpu_write(idx, int'($urandom_range(0, WORDS - 1)), NBYTE'($urandom), $urandom);
      end else if (op < 8) begin
        cpu_read(idx, int'($urandom_range(0, WORDS - 1)));
      end else begin
        rand_line();
        do_fill(idx, int'($urandom_range(0, WORDS - 1)), dd,
                int'($urandom_range(0, WORDS - 1)), int'($urandom_range(0, 3)),
                1'b1, (op == 9 && $urandom_range(0, 3) == 0) ?
                      int'($urandom_range(1, WORDS - 1)) : WORDS);
      end
    end
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < WORDS; w++)
        cpu_read(i, w);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
